// File: rtl/scrypt_pkg.sv
// Shared widths, types and helpers for the scrypt nonce sweeper.
// The nonce occupies header bits [639:608], LSB at bit 608 (byte 76).
package scrypt_pkg;

    localparam int HDR_W     = 640;
    localparam int HASH_W    = 256;
    localparam int NONCE_W   = 32;
    localparam int NONCE_LSB = 608;

    typedef logic [HDR_W-1:0]   header_t;
    typedef logic [HASH_W-1:0]  hash_t;
    typedef logic [NONCE_W-1:0] nonce_t;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} sweep_state_t;

    function automatic header_t insert_nonce(header_t h, nonce_t n);
        header_t mask;
        mask = header_t'({NONCE_W{1'b1}}) << NONCE_LSB;
        return (h & ~mask) | (header_t'(n) << NONCE_LSB);
    endfunction

endpackage

// File: rtl/scrypt_core_arbiter.sv
// Lowest-index priority picker: one-hot grant of the lowest set request bit.
// Used both for choosing an idle core and for choosing the winning hit.
module scrypt_core_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant,
    output logic         valid
);

    assign grant = req & (~req + N'(1));
    assign valid = |req;

endmodule

// File: rtl/scrypt_nonce_sweeper.sv
// Sweeps a nonce range across NUM_CORES hash cores and records the first hit.
//   state | meaning
//   IDLE  | waiting for start
//   RUN   | dispatching nonces, collecting results
//   DRAIN | no dispatch, waiting for in-flight cores
//   FIN   | one-cycle done pulse
module scrypt_nonce_sweeper
    import scrypt_pkg::*;
#(
    parameter int NUM_CORES     = 4,
    parameter int STOP_ON_MATCH = 1,
    parameter int CNT_W         = 32
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic                        start,
    input  logic                        abort,
    input  logic [HDR_W-1:0]            header,
    input  logic [HASH_W-1:0]           target,
    input  logic [NONCE_W-1:0]          nonce_start,
    input  logic [CNT_W-1:0]            nonce_count,
    output logic [NUM_CORES-1:0]        core_start,
    output logic [HDR_W*NUM_CORES-1:0]  core_data,
    input  logic [NUM_CORES-1:0]        core_done,
    input  logic [HASH_W*NUM_CORES-1:0] core_hash,
    output logic                        busy,
    output logic                        done,
    output logic                        aborted,
    output logic                        match_found,
    output logic [NONCE_W-1:0]          match_nonce,
    output logic [HASH_W-1:0]           match_hash,
    output logic [CNT_W-1:0]            match_count
);

    localparam int PC_W = $clog2(NUM_CORES + 1);

    sweep_state_t         state;
    header_t              hdr_q;
    hash_t                target_q;
    nonce_t               next_nonce;
    logic [CNT_W-1:0]     remaining;
    logic [NUM_CORES-1:0] core_busy;
    nonce_t               core_tag [NUM_CORES];

    logic [NUM_CORES-1:0] idle, returned, hits, disp_grant, hit_grant;
    logic                 disp_ok, hit_any, dispatch;
    nonce_t               hit_nonce;
    hash_t                hit_hash;
    logic [PC_W-1:0]      hit_cnt;
    logic [CNT_W:0]       count_sum;
    logic [CNT_W-1:0]     count_next;

    assign idle = ~core_busy;

    scrypt_core_arbiter #(.N(NUM_CORES)) u_disp_arb (
        .req  (idle),
        .grant(disp_grant),
        .valid(disp_ok)
    );

    scrypt_core_arbiter #(.N(NUM_CORES)) u_hit_arb (
        .req  (hits),
        .grant(hit_grant),
        .valid(hit_any)
    );

    assign dispatch = (state == RUN) && disp_ok && (remaining != '0);

    // Results from cores that were never dispatched are dropped here.
    always_comb begin
        returned = '0;
        hits     = '0;
        if (state == RUN || state == DRAIN) begin
            returned = core_done & core_busy;
            for (int i = 0; i < NUM_CORES; i++)
                hits[i] = returned[i] && (core_hash[i*HASH_W +: HASH_W] <= target_q);
        end
    end

    always_comb begin
        hit_nonce = '0;
        hit_hash  = '0;
        hit_cnt   = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            if (hit_grant[i]) begin
                hit_nonce = core_tag[i];
                hit_hash  = core_hash[i*HASH_W +: HASH_W];
            end
            hit_cnt = hit_cnt + PC_W'(hits[i]);
        end
        count_sum  = {1'b0, match_count} + (CNT_W+1)'(hit_cnt);
        count_next = count_sum[CNT_W] ? '1 : count_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state       <= IDLE;
            hdr_q       <= '0;
            target_q    <= '0;
            next_nonce  <= '0;
            remaining   <= '0;
            core_busy   <= '0;
            core_start  <= '0;
            core_data   <= '0;
            for (int i = 0; i < NUM_CORES; i++)
                core_tag[i] <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            match_found <= 1'b0;
            match_nonce <= '0;
            match_hash  <= '0;
            match_count <= '0;
        end else begin
            core_start <= '0;
            done       <= 1'b0;
            core_busy  <= (core_busy & ~returned) | (dispatch ? disp_grant : '0);

            if (dispatch) begin
                core_start <= disp_grant;
                next_nonce <= next_nonce + NONCE_W'(1);
                remaining  <= remaining - CNT_W'(1);
                for (int i = 0; i < NUM_CORES; i++) begin
                    if (disp_grant[i]) begin
                        core_data[i*HDR_W +: HDR_W] <= insert_nonce(hdr_q, next_nonce);
                        core_tag[i]                 <= next_nonce;
                    end
                end
            end

            // The first recorded match of a job is never overwritten.
            if (hit_any) begin
                match_count <= count_next;
                if (!match_found) begin
                    match_found <= 1'b1;
                    match_nonce <= hit_nonce;
                    match_hash  <= hit_hash;
                end
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        hdr_q       <= header;
                        target_q    <= target;
                        next_nonce  <= nonce_start;
                        remaining   <= nonce_count;
                        match_found <= 1'b0;
                        match_nonce <= '0;
                        match_hash  <= '0;
                        match_count <= '0;
                        aborted     <= 1'b0;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (abort) begin
                        aborted <= 1'b1;
                        state   <= DRAIN;
                    end else if (STOP_ON_MATCH != 0 && hit_any) begin
                        state <= DRAIN;
                    end else if (remaining == '0) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (core_busy == '0) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_scrypt_nonce_sweeper.sv
// Self-checking bench: two sweepers (stop-on-match and full sweep) with a
// fixed-latency behavioural core model, a job table and random jobs.
module tb_scrypt_nonce_sweeper;

    localparam int NC  = 4;
    localparam int LAT = 20;

    logic clk = 1'b0;
    logic n_rst = 1'b0;
    logic abort = 1'b0;
    logic start [2];
    logic [639:0] header;
    logic [255:0] target;
    logic [31:0]  nonce_start, nonce_count;
    logic [NC-1:0]     core_start [2];
    logic [NC-1:0]     core_done  [2];
    logic [640*NC-1:0] core_data  [2];
    logic [256*NC-1:0] core_hash  [2];
    logic busy [2], done [2], aborted [2], match_found [2];
    logic [31:0]  match_nonce [2], match_count [2];
    logic [255:0] match_hash [2];

    always #5 clk = ~clk;

    scrypt_nonce_sweeper #(.NUM_CORES(NC), .STOP_ON_MATCH(1), .CNT_W(32)) dut_stop (
        .clk(clk), .n_rst(n_rst), .start(start[0]), .abort(abort),
        .header(header), .target(target), .nonce_start(nonce_start), .nonce_count(nonce_count),
        .core_start(core_start[0]), .core_data(core_data[0]),
        .core_done(core_done[0]), .core_hash(core_hash[0]),
        .busy(busy[0]), .done(done[0]), .aborted(aborted[0]), .match_found(match_found[0]),
        .match_nonce(match_nonce[0]), .match_hash(match_hash[0]), .match_count(match_count[0]));

    scrypt_nonce_sweeper #(.NUM_CORES(NC), .STOP_ON_MATCH(0), .CNT_W(32)) dut_sweep (
        .clk(clk), .n_rst(n_rst), .start(start[1]), .abort(abort),
        .header(header), .target(target), .nonce_start(nonce_start), .nonce_count(nonce_count),
        .core_start(core_start[1]), .core_data(core_data[1]),
        .core_done(core_done[1]), .core_hash(core_hash[1]),
        .busy(busy[1]), .done(done[1]), .aborted(aborted[1]), .match_found(match_found[1]),
        .match_nonce(match_nonce[1]), .match_hash(match_hash[1]), .match_count(match_count[1]));

    typedef struct {
        int           dut;
        logic [31:0]  ns;
        logic [31:0]  cnt;
        logic [255:0] tgt;
        bit           h0e;
        logic [31:0]  h0;
        bit           h1e;
        logic [31:0]  h1;
        int           abort_at;
        int           mid_at;
        int           exp_disp;
        bit           exp_found;
        logic [31:0]  exp_nonce;
        int           exp_count;
        int           hits_total;
        bit           exp_abort;
        int           exp_done_at;
        logic [639:0] hdr;
    } job_t;

    int checks = 0;
    int failures = 0;

    // Core model state, shared with the job tasks.
    int           cyc = 0;
    int           lat [2][NC];
    logic [31:0]  tag [2][NC];
    bit           hit_en [2];
    logic [31:0]  hit_n [2];
    logic [255:0] tgt_exp;
    logic [639:0] header_exp;
    logic [31:0]  disp_log [$];
    int           disp_cyc [$];
    int           proto_err = 0;
    int           first_hit_cyc = -1;
    int           last_done_cyc = -1;

    function automatic logic [255:0] hash_of(bit e0, logic [31:0] n0, bit e1, logic [31:0] n1,
                                             logic [31:0] n);
        if ((e0 && n == n0) || (e1 && n == n1)) return '0;
        return {224'h0, n} ^ {256{1'b1}};
    endfunction

    always @(negedge clk) begin
        logic [255:0] h;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int c = 0; c < NC; c++) begin
                core_done[d][c] = 1'b0;
                if (!n_rst) begin
                    lat[d][c] = 0;
                    core_hash[d][c*256 +: 256] = '0;
                end else begin
                    if (lat[d][c] > 0) begin
                        lat[d][c]--;
                        if (lat[d][c] == 0) begin
                            h = hash_of(hit_en[0], hit_n[0], hit_en[1], hit_n[1], tag[d][c]);
                            core_done[d][c] = 1'b1;
                            core_hash[d][c*256 +: 256] = h;
                            last_done_cyc = cyc;
                            if (h <= tgt_exp && first_hit_cyc < 0) first_hit_cyc = cyc;
                        end
                    end
                    if (core_start[d][c]) begin
                        if (lat[d][c] != 0) proto_err++;
                        lat[d][c] = LAT;
                        tag[d][c] = core_data[d][c*640 + 608 +: 32];
                        if (core_data[d][c*640 +: 608] != header_exp[607:0]) proto_err++;
                        disp_log.push_back(tag[d][c]);
                        disp_cyc.push_back(cyc);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic job_t mk(int dut, logic [31:0] ns, logic [31:0] cnt, logic [255:0] tgt,
                                bit h0e, logic [31:0] h0, bit h1e, logic [31:0] h1,
                                int abort_at, int mid_at, int exp_disp, bit exp_found,
                                logic [31:0] exp_nonce, int exp_count, bit exp_abort, int exp_done_at);
        job_t j;
        j.dut = dut; j.ns = ns; j.cnt = cnt; j.tgt = tgt;
        j.h0e = h0e; j.h0 = h0; j.h1e = h1e; j.h1 = h1;
        j.abort_at = abort_at; j.mid_at = mid_at;
        j.exp_disp = exp_disp; j.exp_found = exp_found; j.exp_nonce = exp_nonce;
        j.exp_count = exp_count; j.hits_total = exp_count; j.exp_abort = exp_abort;
        j.exp_done_at = exp_done_at;
        j.hdr = {80{8'h01}};
        return j;
    endfunction

    // Reference expectations straight from the sweep rules.
    function automatic job_t predict(job_t j);
        int first;
        int n;
        logic [31:0] v;
        first = -1;
        n = 0;
        for (int k = 0; k < int'(j.cnt); k++) begin
            v = j.ns + 32'(k);
            if (hash_of(j.h0e, j.h0, j.h1e, j.h1, v) <= j.tgt) begin
                n++;
                if (first < 0) first = k;
            end
        end
        j.exp_found  = (first >= 0);
        j.exp_nonce  = (first >= 0) ? j.ns + 32'(first) : 32'h0;
        j.hits_total = n;
        if (j.dut == 1) begin
            j.exp_disp  = int'(j.cnt);
            j.exp_count = n;
        end else begin
            j.exp_disp  = (first < 0) ? int'(j.cnt) : -1;
            j.exp_count = (first < 0) ? 0 : -1;
        end
        j.exp_abort   = 1'b0;
        j.exp_done_at = (j.cnt == 0) ? 3 : -1;
        j.abort_at    = -1;
        j.mid_at      = -1;
        return j;
    endfunction

    task automatic launch(input job_t j);
        disp_log.delete();
        disp_cyc.delete();
        proto_err = 0;
        first_hit_cyc = -1;
        last_done_cyc = -1;
        hit_en[0] = j.h0e; hit_n[0] = j.h0;
        hit_en[1] = j.h1e; hit_n[1] = j.h1;
        tgt_exp = j.tgt;
        header_exp = j.hdr;
        header = j.hdr;
        target = j.tgt;
        nonce_start = j.ns;
        nonce_count = j.cnt;
        start[j.dut] = 1'b1;
        tick();
        start[j.dut] = 1'b0;
    endtask

    task automatic run_job(input job_t j, input int idx);
        int d;
        int k;
        bit seen;
        bit ok;
        logic [255:0] exp_hash;
        string p;
        d = j.dut;
        p = $sformatf("job%0d", idx);
        launch(j);
        seen = 1'b0;
        for (k = 1; k <= 3000; k++) begin
            start[d] = (k == j.mid_at);
            abort = (k == j.abort_at);
            if (k == j.mid_at) begin
                nonce_start = ~j.ns;
                nonce_count = 32'd3;
                header = ~j.hdr;
                target = '1;
            end
            if (done[d]) begin
                seen = 1'b1;
                break;
            end
            tick();
        end
        start[d] = 1'b0;
        abort = 1'b0;
        chk({p, "_done_seen"}, 256'(seen), 256'(1));
        if (j.exp_done_at >= 0) chk({p, "_done_latency"}, 256'(k), 256'(j.exp_done_at));
        ok = (last_done_cyc < cyc);
        for (int c = 0; c < NC; c++) if (lat[d][c] != 0) ok = 1'b0;
        chk({p, "_drained_before_done"}, 256'(ok), 256'(1));
        chk({p, "_busy_at_done"}, 256'(busy[d]), 256'(0));
        chk({p, "_aborted"}, 256'(aborted[d]), 256'(j.exp_abort));
        chk({p, "_match_found"}, 256'(match_found[d]), 256'(j.exp_found));
        chk({p, "_match_nonce"}, 256'(match_nonce[d]), 256'(j.exp_nonce));
        exp_hash = j.exp_found ? hash_of(j.h0e, j.h0, j.h1e, j.h1, j.exp_nonce) : '0;
        chk({p, "_match_hash"}, match_hash[d], exp_hash);
        if (j.exp_count >= 0) begin
            chk({p, "_match_count"}, 256'(match_count[d]), 256'(j.exp_count));
        end else begin
            ok = (match_count[d] >= 1) && (match_count[d] <= 32'(j.hits_total));
            chk({p, "_match_count_range"}, 256'(ok), 256'(1));
        end
        if (j.exp_disp >= 0) chk({p, "_dispatches"}, 256'(disp_log.size()), 256'(j.exp_disp));
        ok = 1'b1;
        foreach (disp_log[i]) if (disp_log[i] != j.ns + 32'(i)) ok = 1'b0;
        chk({p, "_nonce_order"}, 256'(ok), 256'(1));
        chk({p, "_core_data_errors"}, 256'(proto_err), 256'(0));
        if (d == 0 && first_hit_cyc >= 0) begin
            ok = 1'b1;
            foreach (disp_cyc[i]) if (disp_cyc[i] > first_hit_cyc + 1) ok = 1'b0;
            chk({p, "_no_dispatch_after_hit"}, 256'(ok), 256'(1));
        end
        tick();
        chk({p, "_done_one_cycle"}, 256'({done[d], busy[d]}), 256'(0));
    endtask

    function automatic logic outputs_nonzero(int d);
        return (|core_start[d]) | (|core_data[d]) | busy[d] | done[d] | aborted[d] |
               match_found[d] | (|match_nonce[d]) | (|match_hash[d]) | (|match_count[d]);
    endfunction

    initial begin
        job_t tbl [8];
        job_t j;
        logic [639:0] rh;

        start[0] = 1'b0;
        start[1] = 1'b0;
        header = '0;
        target = '0;
        nonce_start = '0;
        nonce_count = '0;
        tgt_exp = '0;
        header_exp = '0;
        hit_en[0] = 1'b0; hit_en[1] = 1'b0;
        hit_n[0] = '0;    hit_n[1] = '0;

        //            dut ns            cnt  tgt          h0e h0 h1e h1 abrt mid disp fnd nonce cnt ab done
        tbl[0] = mk(0, 32'h0,        10,  256'h0,      0, 0, 0, 0, -1, -1, 10, 0, 0, 0, 0, -1);
        tbl[1] = mk(0, 32'h0,        10,  256'h1,      1, 5, 0, 0, -1, -1, -1, 1, 5, 1, 0, -1);
        tbl[2] = mk(1, 32'h0,        10,  256'h1,      1, 3, 1, 7, -1, -1, 10, 1, 3, 2, 0, -1);
        tbl[3] = mk(0, 32'hFFFFFFFE, 4,   256'h0,      0, 0, 0, 0, -1, -1, 4,  0, 0, 0, 0, -1);
        tbl[4] = mk(0, 32'h1000,     100, 256'h0,      0, 0, 0, 0, 5,  3,  4,  0, 0, 0, 1, -1);
        tbl[5] = mk(0, 32'h77,       0,   256'h0,      0, 0, 0, 0, -1, -1, 0,  0, 0, 0, 0, 3);
        tbl[6] = mk(1, 32'h0,        4,   ~256'h2,     0, 0, 0, 0, -1, -1, 4,  1, 2, 2, 0, -1);
        tbl[7] = mk(0, 32'h0,        4,   ~256'h2,     0, 0, 0, 0, -1, -1, 4,  1, 2, 2, 0, -1);

        repeat (3) tick();
        chk("reset_outputs_dut_stop", 256'(outputs_nonzero(0)), 256'(0));
        chk("reset_outputs_dut_sweep", 256'(outputs_nonzero(1)), 256'(0));
        n_rst = 1'b1;
        repeat (2) tick();
        chk("idle_after_reset", 256'(outputs_nonzero(0) | outputs_nonzero(1)), 256'(0));

        for (int t = 0; t < 8; t++) begin
            run_job(tbl[t], t);
            repeat (2) tick();
        end

        for (int r = 0; r < 10; r++) begin
            for (int w = 0; w < 20; w++) rh[w*32 +: 32] = $urandom;
            j.dut = r % 2;
            j.ns  = $urandom_range(0, 1) ? $urandom : 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
            j.cnt = 32'($urandom_range(0, 12));
            j.tgt = $urandom_range(0, 3) == 0 ? ~256'(32'($urandom_range(0, 15))) : 256'h1;
            j.h0e = 1'($urandom_range(0, 1));
            j.h0  = j.ns + 32'($urandom_range(0, 14));
            j.h1e = 1'($urandom_range(0, 1));
            j.h1  = j.ns + 32'($urandom_range(0, 14));
            j.hdr = rh;
            j = predict(j);
            run_job(j, 100 + r);
            repeat (2) tick();
        end

        // Asynchronous reset in the middle of a job that already holds a match.
        j = mk(1, 32'h500, 50, 256'h1, 1, 32'h500, 0, 0, -1, -1, 50, 1, 32'h500, 1, 0, -1);
        launch(j);
        repeat (25) tick();
        chk("pre_reset_busy_and_match", 256'({busy[1], match_found[1]}), 256'(2'b11));
        #2;
        n_rst = 1'b0;
        #1;
        chk("async_reset_dut_sweep", 256'(outputs_nonzero(1)), 256'(0));
        chk("async_reset_dut_stop", 256'(outputs_nonzero(0)), 256'(0));
        tick();
        n_rst = 1'b1;
        repeat (3) tick();
        chk("idle_after_async_reset", 256'(outputs_nonzero(1)), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
